// File: rtl/sfif_pkg.sv
// Shared constants and FSM state type for the SFIF RX capture write-side sequencer.
package sfif_pkg;

   localparam int ADDR_W    = 11;
   localparam int MIN_ROOM  = 8;
   localparam int CNT_W     = 16;
   localparam int BUF_DEPTH = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      CAPTURE,
      DRAIN,
      DONE
   } sfif_state_e;

endpackage

// File: rtl/sfif_wr_window.sv
// Start/end pipeline that opens the buffer write window one cycle after an admitted
// start and closes it two cycles after the matching end (timestamp + payload pipeline).
module sfif_wr_window
   import sfif_pkg::*;
(
   input  logic clk_125,
   input  logic rstn,
   input  logic start,
   input  logic tlp_end,
   output logic win,
   output logic close
);

   logic       in_tlp;
   logic       pend;
   logic [1:0] end_sr;
   logic       end_ok;

   // Only ends that belong to an admitted TLP enter the close pipeline.
   assign end_ok = tlp_end & (in_tlp | start);
   assign close  = win & end_sr[1];

   always_ff @(posedge clk_125 or negedge rstn) begin
      if (!rstn) begin
         in_tlp <= 1'b0;
         pend   <= 1'b0;
         end_sr <= 2'b00;
         win    <= 1'b0;
      end else begin
         end_sr <= {end_sr[0], end_ok};

         if (start)
            in_tlp <= ~tlp_end;
         else if (tlp_end)
            in_tlp <= 1'b0;

         // A start that lands while the previous close is still in flight
         // must keep the window open when that close arrives.
         if (close)
            pend <= 1'b0;
         else if (start && (end_sr != 2'b00))
            pend <= 1'b1;

         if (start)
            win <= 1'b1;
         else if (close)
            win <= pend;
      end
   end

endmodule

// File: rtl/sfif_rx_capture_ctrl.sv
// Capture-session sequencer: arms a session, admits or drops TLPs, drives the
// capture buffer write enable/address and reports session status.
module sfif_rx_capture_ctrl #(
   parameter int ADDR_W   = sfif_pkg::ADDR_W,
   parameter int MIN_ROOM = sfif_pkg::MIN_ROOM,
   parameter int CNT_W    = sfif_pkg::CNT_W
) (
   input  logic                  clk_125,
   input  logic                  rstn,
   input  logic                  arm,
   input  logic                  abort,
   input  logic [CNT_W-1:0]      tlp_limit,
   input  logic                  rx64_st,
   input  logic                  rx64_end,
   input  logic                  rx64_filter,
   output logic                  wren,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic                  capturing,
   output logic                  done,
   output logic                  overflow,
   output logic [CNT_W-1:0]      tlp_count,
   output logic [CNT_W-1:0]      drop_count,
   output sfif_pkg::sfif_state_e fsm_state
);
   import sfif_pkg::*;

   localparam int                DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]   ROOM_LIM = (ADDR_W + 1)'(DEPTH - MIN_ROOM);
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   sfif_state_e      state, state_nxt;
   logic [CNT_W-1:0] adm_count;
   logic             admit_zone, limit_ok, limit_hit, room_ok, at_max;
   logic             st_seen, st_filt, st_refuse, st_adm, arm_go;
   logic             win, close;

   assign admit_zone = (state == ARMED) || (state == CAPTURE);
   assign limit_ok   = (tlp_limit == '0) || (adm_count < tlp_limit);
   assign limit_hit  = (tlp_limit != '0) && (tlp_count >= tlp_limit);
   assign room_ok    = ({1'b0, wr_addr} <= ROOM_LIM);
   assign at_max     = (wr_addr == ADDR_MAX);

   // Starts beyond the TLP limit are ignored outright, not counted as drops.
   assign st_seen   = rx64_st & admit_zone & ~abort & limit_ok;
   assign st_filt   = st_seen & rx64_filter;
   assign st_refuse = st_seen & ~rx64_filter & ~room_ok;
   assign st_adm    = st_seen & ~rx64_filter & room_ok;
   assign arm_go    = arm & ((state == IDLE) || (state == DONE));

   assign wren      = win & ~at_max;
   assign capturing = admit_zone;
   assign fsm_state = state;

   sfif_wr_window u_wr_window (
      .clk_125 (clk_125),
      .rstn    (rstn),
      .start   (st_adm),
      .tlp_end (rx64_end),
      .win     (win),
      .close   (close)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (arm) state_nxt = ARMED;
         ARMED: begin
            if (abort)          state_nxt = IDLE;
            else if (st_adm)    state_nxt = CAPTURE;
            else if (st_refuse) state_nxt = DRAIN;
         end
         CAPTURE: if (abort || st_refuse || limit_hit) state_nxt = DRAIN;
         DRAIN:   if (!win) state_nxt = DONE;
         DONE:    if (arm) state_nxt = ARMED;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_125 or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk_125 or negedge rstn) begin
      if (!rstn) begin
         wr_addr    <= '0;
         tlp_count  <= '0;
         drop_count <= '0;
         adm_count  <= '0;
         done       <= 1'b0;
         overflow   <= 1'b0;
      end else if (arm_go) begin
         wr_addr    <= '0;
         tlp_count  <= '0;
         drop_count <= '0;
         adm_count  <= '0;
         done       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (wren)
            wr_addr <= wr_addr + ADDR_W'(1);
         if (close && (tlp_count != CNT_MAX))
            tlp_count <= tlp_count + CNT_W'(1);
         if ((st_filt || st_refuse) && (drop_count != CNT_MAX))
            drop_count <= drop_count + CNT_W'(1);
         if (st_adm && (adm_count != CNT_MAX))
            adm_count <= adm_count + CNT_W'(1);
         // A write attempted at the last address is inhibited and flagged.
         if (st_refuse || (win && at_max))
            overflow <= 1'b1;
         if ((state == DRAIN) && !win)
            done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sfif_rx_capture_ctrl.sv
// Directed + randomized bench for sfif_rx_capture_ctrl with a per-cycle reference
// model built from TLP-level window intervals.
module tb_sfif_rx_capture_ctrl;
   import sfif_pkg::*;

   localparam int N    = 16384;
   localparam int MAXA = BUF_DEPTH - 1;

   logic              clk_125 = 1'b0;
   logic              rstn, arm, abort, rx64_st, rx64_end, rx64_filter;
   logic [CNT_W-1:0]  tlp_limit;
   logic              wren, capturing, done, overflow;
   logic [ADDR_W-1:0] wr_addr;
   logic [CNT_W-1:0]  tlp_count, drop_count;
   sfif_state_e       fsm_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   // Reference model: per-cycle window intervals and event marks, plus an
   // expected queue of window-close cycles for tlp_count.
   bit          win_exp[N];
   bit          drop_at[N];
   bit          ovf_at[N];
   bit          arm_at[N];
   logic [31:0] exp_q[$];
   int          m_fill, m_tc, m_drop, m_adm, m_limit;
   bit          m_ovf, m_acc;

   sfif_rx_capture_ctrl dut (
      .clk_125     (clk_125),
      .rstn        (rstn),
      .arm         (arm),
      .abort       (abort),
      .tlp_limit   (tlp_limit),
      .rx64_st     (rx64_st),
      .rx64_end    (rx64_end),
      .rx64_filter (rx64_filter),
      .wren        (wren),
      .wr_addr     (wr_addr),
      .capturing   (capturing),
      .done        (done),
      .overflow    (overflow),
      .tlp_count   (tlp_count),
      .drop_count  (drop_count),
      .fsm_state   (fsm_state)
   );

   // clock / cycle counter
   always #4 clk_125 = ~clk_125;
   always @(posedge clk_125) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // per-cycle scoreboard, sampled mid-cycle
   always @(negedge clk_125) begin
      if (chk_en) begin
         bit exp_w;
         exp_w = win_exp[cyc] && (m_fill != MAXA);
         chk("wren", 32'(wren), 32'(exp_w));
         chk("wr_addr", 32'(wr_addr), 32'(m_fill));
         chk("tlp_count", 32'(tlp_count), 32'(m_tc));
         chk("drop_count", 32'(drop_count), 32'(m_drop));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         if (arm_at[cyc]) begin
            m_fill = 0; m_tc = 0; m_drop = 0; m_ovf = 1'b0;
         end else begin
            if (ovf_at[cyc] || (win_exp[cyc] && (m_fill == MAXA))) m_ovf = 1'b1;
            if (exp_w) m_fill++;
            if (drop_at[cyc]) m_drop++;
            if ((exp_q.size() > 0) && (exp_q[0] == 32'(cyc))) begin
               void'(exp_q.pop_front());
               m_tc++;
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk_125);
      #1;
   endtask

   task automatic set_limit(input int v);
      tlp_limit = CNT_W'(v);
      m_limit   = v;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      arm_at[cyc] = 1'b1;
      m_acc = 1'b1;
      m_adm = 0;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      m_acc = 1'b0;
      tick();
      abort = 1'b0;
   endtask

   task automatic send(input int len, input bit filt, input int gap, input int abort_at);
      int t, e;
      t = cyc;
      e = t + len - 1;
      if (m_acc && ((m_limit == 0) || (m_adm < m_limit))) begin
         if (filt) begin
            drop_at[t] = 1'b1;
         end else if ((BUF_DEPTH - m_fill) >= MIN_ROOM) begin
            for (int c = t + 1; c <= e + 2; c++) win_exp[c] = 1'b1;
            exp_q.push_back(32'(e + 2));
            m_adm++;
         end else begin
            drop_at[t] = 1'b1;
            ovf_at[t]  = 1'b1;
            m_acc      = 1'b0;
         end
      end
      for (int i = 0; i < len; i++) begin
         rx64_st     = (i == 0);
         rx64_filter = (i == 0) && filt;
         rx64_end    = (i == len - 1);
         abort       = (i == abort_at);
         if (i == abort_at) m_acc = 1'b0;
         tick();
      end
      rx64_st = 1'b0; rx64_end = 1'b0; rx64_filter = 1'b0; abort = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic model_reset();
      for (int c = cyc; c < N; c++) begin
         win_exp[c] = 1'b0; drop_at[c] = 1'b0; ovf_at[c] = 1'b0; arm_at[c] = 1'b0;
      end
      exp_q.delete();
      m_fill = 0; m_tc = 0; m_drop = 0; m_ovf = 1'b0; m_acc = 1'b0; m_adm = 0;
   endtask

   initial begin
      rstn = 1'b0; arm = 1'b0; abort = 1'b0;
      rx64_st = 1'b0; rx64_end = 1'b0; rx64_filter = 1'b0;
      set_limit(0);
      model_reset();
      repeat (3) tick();

      // reset state
      chk("rst_wren", 32'(wren), 32'(0));
      chk("rst_wr_addr", 32'(wr_addr), 32'(0));
      chk("rst_capturing", 32'(capturing), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_state", 32'(fsm_state), 32'(IDLE));
      rstn = 1'b1;
      chk_en = 1'b1;
      tick();

      // single 4-cycle TLP
      do_arm();
      chk("arm_state", 32'(fsm_state), 32'(ARMED));
      chk("arm_capturing", 32'(capturing), 32'(1));
      send(4, 1'b0, 0, -1);
      repeat (3) tick();
      chk("t1_wr_addr", 32'(wr_addr), 32'(5));
      chk("t1_tlp_count", 32'(tlp_count), 32'(1));
      chk("t1_capturing", 32'(capturing), 32'(1));
      chk("t1_state", 32'(fsm_state), 32'(CAPTURE));

      // filtered TLP then a written one
      do_abort();
      repeat (3) tick();
      chk("t2_done_prev", 32'(done), 32'(1));
      chk("t2_state_prev", 32'(fsm_state), 32'(DONE));
      do_arm();
      send(3, 1'b1, 2, -1);
      chk("t2_drop", 32'(drop_count), 32'(1));
      chk("t2_state_armed", 32'(fsm_state), 32'(ARMED));
      send(3, 1'b0, 4, -1);
      chk("t2_tlp_count", 32'(tlp_count), 32'(1));
      chk("t2_wr_addr", 32'(wr_addr), 32'(4));

      // TLP limit with back-to-back TLPs
      do_abort();
      repeat (3) tick();
      set_limit(3);
      do_arm();
      repeat (5) send(4, 1'b0, 0, -1);
      repeat (6) tick();
      chk("t3_done", 32'(done), 32'(1));
      chk("t3_tlp_count", 32'(tlp_count), 32'(3));
      chk("t3_wr_addr", 32'(wr_addr), 32'(13));
      chk("t3_drop", 32'(drop_count), 32'(0));
      chk("t3_state", 32'(fsm_state), 32'(DONE));

      // fill the buffer with random TLPs until room refusal
      set_limit(0);
      do_arm();
      for (int k = 0; (k < 400) && m_acc; k++)
         send($urandom_range(1, 60), ($urandom_range(0, 7) == 0), $urandom_range(0, 3), -1);
      chk("t4_refusal_reached", 32'(m_acc), 32'(0));
      repeat (6) tick();
      chk("t4_overflow", 32'(overflow), 32'(1));
      chk("t4_done", 32'(done), 32'(1));
      chk("t4_state", 32'(fsm_state), 32'(DONE));
      chk("t4_fill_high", 32'(wr_addr >= ADDR_W'(BUF_DEPTH - MIN_ROOM + 1)), 32'(1));
      send(5, 1'b0, 3, -1);
      chk("t4_wr_addr_hold", 32'(wr_addr), 32'(m_fill));
      chk("t4_drop", 32'(drop_count), 32'(m_drop));

      // abort mid-TLP, then abort in ARMED and IDLE
      do_arm();
      send(6, 1'b0, 0, 2);
      chk("t5_state_drain", 32'(fsm_state), 32'(DRAIN));
      chk("t5_done_low", 32'(done), 32'(0));
      repeat (3) tick();
      chk("t5_state_done", 32'(fsm_state), 32'(DONE));
      chk("t5_done", 32'(done), 32'(1));
      chk("t5_tlp_count", 32'(tlp_count), 32'(1));
      chk("t5_wr_addr", 32'(wr_addr), 32'(7));
      do_arm();
      do_abort();
      chk("t5_armed_abort_state", 32'(fsm_state), 32'(IDLE));
      chk("t5_armed_abort_done", 32'(done), 32'(0));
      chk("t5_armed_abort_capt", 32'(capturing), 32'(0));
      do_abort();
      chk("t5_idle_abort_state", 32'(fsm_state), 32'(IDLE));

      // randomized session with a small limit
      set_limit($urandom_range(1, 5));
      do_arm();
      repeat (8) send($urandom_range(1, 8), ($urandom_range(0, 3) == 0), $urandom_range(0, 2), -1);
      repeat (8) tick();
      chk("t7_done", 32'(done), 32'(m_adm == m_limit));
      chk("t7_capturing", 32'(capturing), 32'(m_adm != m_limit));
      do_abort();
      repeat (4) tick();

      // reset in the middle of a write window
      chk_en = 1'b0;
      set_limit(0);
      do_arm();
      rx64_st = 1'b1;
      tick();
      rx64_st = 1'b0;
      repeat (2) tick();
      chk("t6_pre_reset_wren", 32'(wren), 32'(1));
      #2 rstn = 1'b0;
      #1;
      chk("t6_wren", 32'(wren), 32'(0));
      chk("t6_wr_addr", 32'(wr_addr), 32'(0));
      chk("t6_capturing", 32'(capturing), 32'(0));
      chk("t6_state", 32'(fsm_state), 32'(IDLE));
      chk("t6_overflow", 32'(overflow), 32'(0));
      repeat (2) tick();
      rstn = 1'b1;
      model_reset();
      chk_en = 1'b1;
      send(4, 1'b0, 4, -1);
      chk("t6_no_arm_wr_addr", 32'(wr_addr), 32'(0));
      chk("t6_no_arm_tlp_count", 32'(tlp_count), 32'(0));
      chk("t6_no_arm_state", 32'(fsm_state), 32'(IDLE));
      chk_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
